// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: recovers hex digits from a multiplexed active-low 7-segment bus (optional blank digits via SEG_BLANK_DIGIT_EN)
module seg_frame_decoder #(
  parameter int STABLE_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  input  logic       seg_strobe,
  output logic [3:0] value1,
  output logic [3:0] value2,
  output logic [3:0] value3,
  output logic [2:0] blank,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       sync_err
);
  localparam logic [1:0] WAIT0 = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] WAIT2 = 2'd2;
  localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

  // Decoded digit: {invalid, blank, value}
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'b1000000: dec = 6'h00;
      7'b1111001: dec = 6'h01;
      7'b0100100: dec = 6'h02;
      7'b0110000: dec = 6'h03;
      7'b0011001: dec = 6'h04;
      7'b0010010: dec = 6'h05;
      7'b0000010: dec = 6'h06;
      7'b1111000: dec = 6'h07;
      7'b0000000: dec = 6'h08;
      7'b0010000: dec = 6'h09;
      7'b0001000: dec = 6'h0a;
      7'b0000011: dec = 6'h0b;
      7'b1000110: dec = 6'h0c;
      7'b0100001: dec = 6'h0d;
      7'b0000110: dec = 6'h0e;
      7'b0001110: dec = 6'h0f;
`ifdef SEG_BLANK_DIGIT_EN
      7'b1111111: dec = 6'b010000;
`endif
      default:    dec = 6'b100000;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [5:0]  dig1_q, dig1_d, dig2_q, dig2_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] prev_q, prev_d;
  logic        have_prev_q, have_prev_d;
  logic [3:0]  value1_q, value1_d, value2_q, value2_d, value3_q, value3_d;
  logic [2:0]  blank_q, blank_d;
  logic        frame_valid_q, frame_valid_d, seg_err_q, seg_err_d, sync_err_q, sync_err_d;
  logic [5:0]  cur;
  logic [14:0] frame;
  logic        match;

  // Slot sequencing, frame completion and stability counting
  always_comb begin
    cur           = dec(seg_in);
    frame         = {dig1_q[3:0], dig2_q[3:0], cur[3:0], cur[4], dig2_q[4], dig1_q[4]};
    match         = have_prev_q && frame == prev_q;
    state_d       = state_q;
    dig1_d        = dig1_q;
    dig2_d        = dig2_q;
    cnt_d         = cnt_q;
    prev_d        = prev_q;
    have_prev_d   = have_prev_q;
    value1_d      = value1_q;
    value2_d      = value2_q;
    value3_d      = value3_q;
    blank_d       = blank_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    sync_err_d    = 1'b0;
    if (seg_strobe && dig_sel != 2'd3) begin
      if (dig_sel == 2'd0) begin
        dig1_d     = cur;
        state_d    = WAIT1;
        sync_err_d = state_q != WAIT0;
      end else if (dig_sel == 2'd1 && state_q == WAIT1) begin
        dig2_d  = cur;
        state_d = WAIT2;
      end else if (dig_sel == 2'd2 && state_q == WAIT2) begin
        state_d = WAIT0;
        if (dig1_q[5] || dig2_q[5] || cur[5]) begin
          seg_err_d   = 1'b1;
          cnt_d       = 4'd0;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = match ? (cnt_q == STABLE ? cnt_q : cnt_q + 4'd1) : 4'd1;
          if (!match) begin
            prev_d      = frame;
            have_prev_d = 1'b1;
          end
          if (cnt_d == STABLE && !(match && cnt_q == STABLE)) begin
            value1_d      = frame[14:11];
            value2_d      = frame[10:7];
            value3_d      = frame[6:3];
            blank_d       = frame[2:0];
            frame_valid_d = 1'b1;
          end
        end
      end else begin
        sync_err_d = 1'b1;
        state_d    = WAIT0;
      end
    end
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT0;
      dig1_q        <= '0;
      dig2_q        <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      value1_q      <= '0;
      value2_q      <= '0;
      value3_q      <= '0;
      blank_q       <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dig1_q        <= dig1_d;
      dig2_q        <= dig2_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
      value1_q      <= value1_d;
      value2_q      <= value2_d;
      value3_q      <= value3_d;
      blank_q       <= blank_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign value1      = value1_q;
  assign value2      = value2_q;
  assign value3      = value3_q;
  assign blank       = blank_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign sync_err    = sync_err_q;
endmodule
